// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss stopwatch with run/pause/clear FSM, lap capture and 59:59 wrap pulse.
module stopwatch_ctrl #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [5:0] scnds,
    output logic [5:0] mins,
    output logic       oflow,
    output logic       running,
    output logic [1:0] state,
    output logic [5:0] lap_scnds,
    output logic [5:0] lap_mins,
    output logic       lap_valid
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
    localparam logic [26:0] LAST = 27'(TICKS_PER_SEC - 1);
    state_t st;
    logic [26:0] presc;
    logic tick, active;
    assign tick = st == RUN && presc == LAST;
    assign active = st == RUN || st == PAUSE;
    assign state = st;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            presc <= '0;
            scnds <= '0;
            mins <= '0;
            oflow <= 1'b0;
            running <= 1'b0;
            lap_scnds <= '0;
            lap_mins <= '0;
            lap_valid <= 1'b0;
        end else if (clear) begin
            st <= IDLE;
            presc <= '0;
            scnds <= '0;
            mins <= '0;
            oflow <= 1'b0;
            running <= 1'b0;
            lap_scnds <= '0;
            lap_mins <= '0;
            lap_valid <= 1'b0;
        end else begin
            oflow <= tick && scnds == 6'd59 && mins == 6'd59;
            if (st == RUN) presc <= tick ? '0 : presc + 27'd1;
            if (tick) begin
                scnds <= scnds == 6'd59 ? '0 : scnds + 6'd1;
                if (scnds == 6'd59) mins <= mins == 6'd59 ? '0 : mins + 6'd1;
            end
            // start_stop outranks lap; the unused 11 encoding falls back to IDLE
            if (start_stop) begin
                st <= st == RUN ? PAUSE : RUN;
                running <= st != RUN;
            end else begin
                if (!active) st <= IDLE;
                if (lap && active) begin
                    lap_scnds <= scnds;
                    lap_mins <= mins;
                    lap_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scoreboard bench for stopwatch_ctrl at TICKS_PER_SEC=4.
module tb_stopwatch_ctrl;
    logic clk = 1'b0, rst = 1'b1, ss = 1'b0, clr = 1'b0, lp = 1'b0;
    logic [5:0] scnds, mins, lap_scnds, lap_mins;
    logic oflow, running, lap_valid;
    logic [1:0] state;
    int n_cmp = 0, n_bad = 0;
    typedef struct {
        string tag;
        int sig;
        logic [5:0] val;
    } exp_t;
    exp_t exp_q[$];

    stopwatch_ctrl #(.TICKS_PER_SEC(4)) dut (
        .clk(clk), .rst(rst), .start_stop(ss), .clear(clr), .lap(lp),
        .scnds(scnds), .mins(mins), .oflow(oflow), .running(running), .state(state),
        .lap_scnds(lap_scnds), .lap_mins(lap_mins), .lap_valid(lap_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs(int s);
        case (s)
            0: return scnds;
            1: return mins;
            2: return {5'd0, oflow};
            3: return {5'd0, running};
            4: return {4'd0, state};
            5: return lap_scnds;
            6: return lap_mins;
            default: return {5'd0, lap_valid};
        endcase
    endfunction

    task automatic want(string tag, int sig, int val);
        exp_q.push_back('{tag, sig, 6'(val)});
    endtask

    task automatic chk();
        exp_t e;
        logic [5:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs(e.sig);
            n_cmp++;
            assert (o === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
            end
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic all_zero(string tag);
        for (int s = 0; s < 8; s++) want(tag, s, 0);
        chk();
    endtask

    initial begin
        #1;
        all_zero("reset_async");
        step(2);
        rst = 1'b0;
        // basic count: start_stop in cycle 0
        ss = 1'b1; step(1); ss = 1'b0;
        want("run_c1", 3, 1); want("state_c1", 4, 1); want("s_c1", 0, 0); chk();
        step(3); want("s_c4", 0, 0); chk();
        step(1); want("s_c5", 0, 1); chk();
        step(4); want("s_c9", 0, 2); want("m_c9", 1, 0); chk();
        // pause with prescaler held at 2, resume
        step(1);
        ss = 1'b1; step(1); ss = 1'b0;
        want("pause_state", 4, 2); want("pause_run", 3, 0); want("pause_s", 0, 2); chk();
        step(10); want("pause_hold_s", 0, 2); want("pause_hold_st", 4, 2); chk();
        ss = 1'b1; step(1); ss = 1'b0;
        want("resume_run", 3, 1); want("resume_s0", 0, 2); chk();
        step(1); want("resume_s1", 0, 2); chk();
        step(1); want("resume_s2", 0, 3); chk();
        // lap in the tick cycle at 00:07
        step(19); want("pre_lap_s", 0, 7); chk();
        lp = 1'b1; step(1); lp = 1'b0;
        want("lap1_s", 5, 7); want("lap1_m", 6, 0); want("lap1_v", 7, 1); want("lap1_cur", 0, 8); chk();
        step(4); want("pre_lap2", 0, 9); chk();
        lp = 1'b1; step(1); lp = 1'b0;
        want("lap2_s", 5, 9); want("lap2_v", 7, 1); chk();
        // wrap at 59:59
        step(14359);
        want("w59_s", 0, 59); want("w59_m", 1, 59); want("w59_of", 2, 0); chk();
        step(3); want("wtick_s", 0, 59); want("wtick_of", 2, 0); chk();
        step(1);
        want("wrap_s", 0, 0); want("wrap_m", 1, 0); want("wrap_of", 2, 1);
        want("wrap_run", 3, 1); want("wrap_st", 4, 1); chk();
        step(1); want("wrap_of_end", 2, 0); want("wrap_s1", 0, 0); chk();
        // async reset at 01:23
        step(331); want("t123_s", 0, 23); want("t123_m", 1, 1); chk();
        #2 rst = 1'b1;
        #1 all_zero("rst_mid_run");
        step(2);
        rst = 1'b0;
        step(10); want("post_rst_s", 0, 0); want("post_rst_st", 4, 0); want("post_rst_run", 3, 0); chk();
        // priority: clear + start_stop + lap in RUN
        ss = 1'b1; step(1); ss = 1'b0;
        step(4); want("prio_s", 0, 1); chk();
        lp = 1'b1; step(1); lp = 1'b0;
        want("prio_lapv", 7, 1); want("prio_laps", 5, 1); chk();
        clr = 1'b1; ss = 1'b1; lp = 1'b1; step(1); clr = 1'b0; ss = 1'b0; lp = 1'b0;
        all_zero("prio_clear");
        lp = 1'b1; step(1); lp = 1'b0;
        want("idle_lap_v", 7, 0); want("idle_lap_st", 4, 0); chk();
        clr = 1'b1; step(1); clr = 1'b0;
        want("idle_clear_st", 4, 0); want("idle_clear_run", 3, 0); chk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000, meaning clk cycles per second; legal range 2..2^27.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_stop  in  1  single-cycle pulse, run/pause toggle.
REQ-005 SHALL have port clear  in  1  single-cycle pulse, return to IDLE and zero all counts.
REQ-006 SHALL have port lap  in  1  single-cycle pulse, capture current time.
REQ-007 SHALL have port scnds  out  6  current seconds, 0..59.
REQ-008 SHALL have port mins  out  6  current minutes, 0..59.
REQ-009 SHALL have port oflow  out  1  one-cycle pulse on 59:59 -> 00:00 wrap.
REQ-010 SHALL have port running  out  1  high only in RUN.
REQ-011 SHALL have port state  out  2  FSM encoding: IDLE=00, RUN=01, PAUSE=10.
REQ-012 SHALL have port lap_scnds  out  6  captured seconds.
REQ-013 SHALL have port lap_mins  out  6  captured minutes.
REQ-014 SHALL have port lap_valid  out  1  high once a lap has been captured.

Function
REQ-015 SHALL implement FSM IDLE/RUN/PAUSE, all outputs registered; 11 never entered, and decodes to IDLE if reached.
REQ-016 SHALL transition IDLE->RUN on start_stop, RUN->PAUSE on start_stop, PAUSE->RUN on start_stop.
REQ-017 SHALL transition RUN or PAUSE->IDLE on clear; clear in IDLE leaves state IDLE.
REQ-018 SHALL give clear priority over start_stop over lap when asserted in the same cycle; clear+start_stop yields IDLE.
REQ-019 SHALL keep a prescaler (27 bits) that increments only in RUN, wraps TICKS_PER_SEC-1 -> 0, holds in PAUSE, and is 0 in IDLE.
REQ-020 SHALL generate an internal tick in the RUN cycle where prescaler == TICKS_PER_SEC-1.
REQ-021 SHALL increment scnds at the edge ending a tick cycle; latency is start_stop in cycle 0 -> RUN from cycle 1 -> scnds=1 visible in cycle TICKS_PER_SEC+1.
REQ-022 SHALL, on a tick with scnds==59, set scnds=0 and increment mins.
REQ-023 SHALL, on a tick with mins==59 and scnds==59, set both to 0 and assert oflow for exactly the one cycle in which 00:00 is first visible; state stays RUN.
REQ-024 SHALL zero scnds, mins, prescaler, lap_scnds, lap_mins and lap_valid on clear (effective next cycle).
REQ-025 SHALL, on lap in RUN or PAUSE, load lap_scnds/lap_mins with the pre-update scnds/mins of that cycle (a coincident tick is excluded) and set lap_valid=1.
REQ-026 SHALL hold lap_valid=1 until clear or rst; later laps overwrite captured values.
REQ-027 SHALL ignore lap in IDLE.
REQ-028 SHALL ignore a lap coincident with clear.
REQ-029 SHALL resume from the held prescaler value on PAUSE->RUN, so pause time is excluded from the count.
REQ-030 SHALL never let scnds or mins exceed 59.
REQ-031 SHALL keep the count monotonic except at wrap or clear.

Reset
REQ-032 SHALL, while rst=1, immediately and asynchronously force state=IDLE and prescaler, scnds, mins, lap_scnds, lap_mins=0.
REQ-033 SHALL, while rst=1, immediately and asynchronously force oflow, running, lap_valid=0.
REQ-034 SHALL ignore all inputs while rst=1 and process normally from the first rising edge after rst deasserts.
REQ-035 SHALL, on rst mid-RUN, discard the count and require a new start_stop to count again.

Verification (TICKS_PER_SEC=4)
REQ-036 SHALL cover basic count: rst, then start_stop at cycle 0 -> running=1 from cycle 1, scnds=1 at cycle 5, scnds=2 at cycle 9, mins=0.
REQ-037 SHALL cover pause/resume: pause when prescaler=2 -> scnds and prescaler frozen for 10 cycles; start_stop -> next scnds increment 3 cycles after RUN re-entry.
REQ-038 SHALL cover wrap: preload via counting to 59:59 -> next tick gives 00:00 and oflow=1 for one cycle only, running=1.
REQ-039 SHALL cover lap: lap in the tick cycle at 00:07 -> lap_scnds=7, lap_valid=1, scnds=8; a second lap at 00:09 -> lap_scnds=9.
REQ-040 SHALL cover priority: clear+start_stop+lap in the same RUN cycle -> state=IDLE, all counts 0, lap_valid=0; lap alone in IDLE -> lap_valid stays 0.
REQ-041 SHALL cover reset: assert rst between clock edges in RUN at 01:23 -> all outputs 0 and state=00 before the next edge.
